// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared types and constants for the CPU control unit.
//   state_t      : FSM state encoding (ILLEGAL only when CU_ILLEGAL_TRAP_EN is defined)
//   OP_*         : opcode constants for ir[15:12]
//   *_HI / *_LO  : instruction field bit positions
package cpu_pkg;

  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int WADR_HI = 11;
  localparam int WADR_LO = 8;
  localparam int RADR_HI = 7;
  localparam int RADR_LO = 4;
  localparam int SADR_HI = 3;
  localparam int SADR_LO = 0;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_ST  = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_BRZ = 4'hB;
  localparam logic [3:0] OP_BRC = 4'hC;
  localparam logic [3:0] OP_BRN = 4'hD;
  localparam logic [3:0] OP_ILL = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [3:0] {
    RST, FETCH, DECODE, EXECUTE, MEM_RD, WBACK, MEM_WR, HALT
`ifdef CU_ILLEGAL_TRAP_EN
    , ILLEGAL
`endif
  } state_t;

endpackage

// File: rtl/cpu_cu_decode.sv
// cpu_cu_decode -- combinational opcode classifier.
//   i_ir      : instruction register contents
//   o_is_*    : one-hot-ish class of ir[15:12]; NOP matches no class
module cpu_cu_decode
  import cpu_pkg::*;
(
  input  logic [15:0] i_ir,
  output logic        o_is_alu,
  output logic        o_is_ld,
  output logic        o_is_st,
  output logic        o_is_jmp,
  output logic        o_is_br,
  output logic        o_is_halt,
  output logic        o_is_ill
);

  logic [3:0] w_opc;
  assign w_opc = i_ir[OPC_HI:OPC_LO];

  assign o_is_alu  = (w_opc != OP_NOP) && (w_opc < OP_LD);
  assign o_is_ld   = (w_opc == OP_LD);
  assign o_is_st   = (w_opc == OP_ST);
  assign o_is_jmp  = (w_opc == OP_JMP);
  assign o_is_br   = (w_opc == OP_BRZ) || (w_opc == OP_BRC) || (w_opc == OP_BRN);
  assign o_is_halt = (w_opc == OP_HLT);
  assign o_is_ill  = (w_opc == OP_ILL);

endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit -- multi-cycle Moore FSM sequencing fetch/decode/execute.
//   clk, reset (async, active-low)
//   ir, c, n, z                        : instruction and flags from the execution unit
//   adr_sel, ir_ld, pc_inc, pc_ld,
//   reg_w_en, s_sel, mem_w_en          : registered datapath strobes
//   w_adr, r_adr, s_adr, alu_op        : instruction fields passed through
//   halted, illegal                    : sticky status, cleared only by reset
// Optional feature: define CU_ILLEGAL_TRAP_EN to trap opcode E in an ILLEGAL
// state; otherwise opcode E runs as a NOP and illegal is tied low.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int OPC_W  = 4,
  parameter int RADR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       ir,
  input  logic              c,
  input  logic              n,
  input  logic              z,
  output logic              adr_sel,
  output logic              ir_ld,
  output logic              pc_inc,
  output logic              pc_ld,
  output logic              reg_w_en,
  output logic              s_sel,
  output logic              mem_w_en,
  output logic [RADR_W-1:0] w_adr,
  output logic [RADR_W-1:0] r_adr,
  output logic [RADR_W-1:0] s_adr,
  output logic [OPC_W-1:0]  alu_op,
  output logic              halted,
  output logic              illegal
);

  state_t r_state;
  logic   r_adr_sel, r_ir_ld, r_pc_inc, r_pc_ld, r_reg_w_en, r_s_sel, r_mem_w_en;
  logic   r_halted;
  logic   w_is_alu, w_is_ld, w_is_st, w_is_jmp, w_is_br, w_is_halt, w_is_ill;
  logic   w_br_take;

  cpu_cu_decode u_dec (
    .i_ir      (ir),
    .o_is_alu  (w_is_alu),
    .o_is_ld   (w_is_ld),
    .o_is_st   (w_is_st),
    .o_is_jmp  (w_is_jmp),
    .o_is_br   (w_is_br),
    .o_is_halt (w_is_halt),
    .o_is_ill  (w_is_ill)
  );

  assign alu_op = ir[OPC_HI:OPC_LO];
  assign w_adr  = ir[WADR_HI:WADR_LO];
  assign r_adr  = ir[RADR_HI:RADR_LO];
  assign s_adr  = ir[SADR_HI:SADR_LO];

  // Flags come from a register that only updates on an ALU execute, so they
  // are stable from DECODE through EXECUTE; capturing them on the edge into
  // EXECUTE gives the same value as EXECUTE sees and keeps pc_ld registered.
  assign w_br_take = ((alu_op == OP_BRZ) && z) ||
                     ((alu_op == OP_BRC) && c) ||
                     ((alu_op == OP_BRN) && n);

`ifdef CU_ILLEGAL_TRAP_EN
  logic r_illegal;
  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

  // Strobes are registered: each branch loads the values for the state it
  // enters, so outputs are a pure function of the registered state and the
  // async reset clears them without waiting for an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= RST;
      r_adr_sel  <= 1'b0;
      r_ir_ld    <= 1'b0;
      r_pc_inc   <= 1'b0;
      r_pc_ld    <= 1'b0;
      r_reg_w_en <= 1'b0;
      r_s_sel    <= 1'b0;
      r_mem_w_en <= 1'b0;
      r_halted   <= 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
      r_illegal  <= 1'b0;
`endif
    end else begin
      r_adr_sel  <= 1'b0;
      r_ir_ld    <= 1'b0;
      r_pc_inc   <= 1'b0;
      r_pc_ld    <= 1'b0;
      r_reg_w_en <= 1'b0;
      r_s_sel    <= 1'b0;
      r_mem_w_en <= 1'b0;
      case (r_state)
        RST, EXECUTE, WBACK, MEM_WR: begin
          r_state   <= FETCH;
          r_adr_sel <= 1'b1;
          r_ir_ld   <= 1'b1;
          r_pc_inc  <= 1'b1;
        end
        FETCH: r_state <= DECODE;
        DECODE: begin
          if (w_is_ld) begin
            r_state <= MEM_RD;
          end else if (w_is_st) begin
            r_state    <= MEM_WR;
            r_mem_w_en <= 1'b1;
          end else if (w_is_halt) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end else if (w_is_ill) begin
`ifdef CU_ILLEGAL_TRAP_EN
            r_state   <= ILLEGAL;
            r_illegal <= 1'b1;
`else
            r_state <= EXECUTE;  // untrapped: behaves as NOP
`endif
          end else begin
            r_state    <= EXECUTE;
            r_reg_w_en <= w_is_alu;
            r_pc_ld    <= w_is_jmp || (w_is_br && w_br_take);
          end
        end
        MEM_RD: begin
          r_state    <= WBACK;
          r_reg_w_en <= 1'b1;
          r_s_sel    <= 1'b1;
        end
        HALT: r_state <= HALT;
`ifdef CU_ILLEGAL_TRAP_EN
        ILLEGAL: r_state <= ILLEGAL;
`endif
        default: r_state <= RST;
      endcase
    end
  end

  assign adr_sel  = r_adr_sel;
  assign ir_ld    = r_ir_ld;
  assign pc_inc   = r_pc_inc;
  assign pc_ld    = r_pc_ld;
  assign reg_w_en = r_reg_w_en;
  assign s_sel    = r_s_sel;
  assign mem_w_en = r_mem_w_en;
  assign halted   = r_halted;

endmodule

// File: doc/cpu_control_unit.md
CPU_CONTROL_UNIT -- requirements
Module: cpu_control_unit

Interface
REQ-001 Parameters SHALL be: OPC_W, 4, opcode width (IR[15:12]); RADR_W, 4, register-address field width.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 ir  input  16  instruction register contents from the execution unit.
REQ-005 c, n, z  input  1 each  registered carry/negative/zero flags from the execution unit.
REQ-006 Strobes, output, 1 each, SHALL be:
  - adr_sel: 1 = PC drives the address bus.
  - ir_ld: load the instruction register.
  - pc_inc: increment the PC.
  - pc_ld: load the PC.
  - reg_w_en: register-file write.
  - s_sel: 1 = memory data to the register file, 0 = ALU result.
  - mem_w_en: memory write.
REQ-007 Field outputs SHALL be w_adr, r_adr, s_adr (output, 4 each) = ir[11:8], ir[7:4], ir[3:0], and alu_op (output, 4) = ir[15:12].
REQ-008 Status outputs SHALL be halted (output, 1) and illegal (output, 1), both sticky.

Function
REQ-009 The FSM SHALL have states RST, FETCH, DECODE, EXECUTE, MEM_RD, WBACK, MEM_WR, HALT, ILLEGAL; all outputs SHALL be decoded from the registered state only (Moore).
REQ-010 Opcode map (ir[15:12]) SHALL be:
  - 0: NOP.
  - 1-7: ALU op, R[w] <= ALU(R[r], R[s]).
  - 8: LD, R[w] <= M[R[r]].
  - 9: ST, M[R[r]] <= R[s].
  - A: JMP, PC <= R[r].
  - B/C/D: branch if z/c/n, PC <= R[r].
  - E: illegal.
  - F: HALT.
REQ-011 RST SHALL go to FETCH on the first clock after reset deassertion, with all strobes low.
REQ-012 FETCH SHALL assert adr_sel, ir_ld and pc_inc for exactly one cycle, then go to DECODE.
REQ-013 DECODE SHALL assert no strobes and branch per opcode: 0-7, A-D to EXECUTE; 8 to MEM_RD; 9 to MEM_WR; F to HALT; E per REQ-022.
REQ-014 EXECUTE SHALL assert, for one cycle:
  - opcodes 1-7: reg_w_en with s_sel=0;
  - A: pc_ld;
  - B/C/D: pc_ld only if z/c/n=1;
  - 0: no strobes.
  It SHALL then go to FETCH.
REQ-015 MEM_RD SHALL drive adr_sel=0 only, then go to WBACK; WBACK SHALL assert reg_w_en with s_sel=1 and adr_sel=0, then go to FETCH.
REQ-016 MEM_WR SHALL assert mem_w_en with adr_sel=0 for exactly one cycle, then go to FETCH.
REQ-017 Latency SHALL be 3 cycles for NOP, ALU, ST, JMP and branches, and 4 cycles for LD, counted FETCH to the next FETCH.
REQ-018 Flags SHALL be sampled in EXECUTE and reflect the last ALU instruction; a branch directly after LD or ST SHALL use the pre-existing flags.
REQ-019 HALT SHALL be absorbing: halted=1, all strobes low, exit only via reset.
REQ-020 At most one of ir_ld, pc_ld, reg_w_en, mem_w_en SHALL be high in any cycle; pc_inc SHALL never be high together with pc_ld.

Reset
REQ-021 Reset assertion SHALL immediately (asynchronously) force state RST, all strobes 0, adr_sel 0, and halted and illegal 0, including mid-MEM_WR, where mem_w_en SHALL drop without waiting for a clock edge.

Configuration
REQ-022 With CU_ILLEGAL_TRAP_EN defined, opcode E SHALL go from DECODE to ILLEGAL, which sets illegal=1, holds all strobes low and is exited only by reset; without it, opcode E SHALL execute as NOP, illegal SHALL be tied 0, and the ILLEGAL state SHALL be absent.

Structure
REQ-023 Package cpu_pkg SHALL hold the state enumeration, the opcode constants (OP_NOP, OP_LD, OP_ST, OP_JMP, OP_BRZ, OP_BRC, OP_BRN, OP_ILL, OP_HLT) and the field bit positions.
REQ-024 A combinational sub-module cpu_cu_decode SHALL classify ir into is_alu, is_ld, is_st, is_jmp, is_br, is_halt and is_ill; cpu_control_unit SHALL hold the FSM.

Verification
REQ-025 Release reset with ir=0x1123 -> RST, then FETCH (adr_sel=ir_ld=pc_inc=1), DECODE, EXECUTE (reg_w_en=1, s_sel=0, alu_op=1, w_adr=1), then FETCH.
REQ-026 ir=0x8050 -> MEM_RD, then WBACK with reg_w_en=1, s_sel=1, adr_sel=0, w_adr=0, r_adr=5; total 4 cycles.
REQ-027 ir=0xB030 with z=0 -> no pc_ld; with z=1 -> pc_ld=1 in EXECUTE only; pc_inc is never coincident with pc_ld.
REQ-028 ir=0x9012, then assert reset during MEM_WR -> mem_w_en falls before the next clock edge; after release the FSM is in RST, then FETCH.
REQ-029 ir=0xF000 -> halted=1 with strobes quiescent for 20 cycles; reset clears halted.
REQ-030 ir=0xE000 -> with CU_ILLEGAL_TRAP_EN: illegal=1 and the FSM stalls; without it: NOP timing of 3 cycles and illegal=0.
